// File: rtl/metropolis_accept.sv
// Metropolis acceptance test: two-stage pipeline deciding accept when dE <= 0
// or beta*dE < -ln(u), with delivered/accepted decision counters.
module metropolis_accept #(
   parameter int TAG_W = 16,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_de,
   input  logic [31:0]      in_beta,
   input  logic [31:0]      in_nlog,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_accept,
   output logic [TAG_W-1:0] out_tag,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] n_total,
   output logic [CNT_W-1:0] n_accept
);

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // The whole pipe shifts together whenever the output slot is free or being
   // drained, so in_ready is a function of out_ready and registered state only.
   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   logic             s1_valid;
   logic             s1_force;
   logic [31:0]      s1_prod;
   logic [31:0]      s1_nlog;
   logic [TAG_W-1:0] s1_tag;

   logic        de_nonpos;
   logic [63:0] raw_prod;
   logic [63:0] shifted;
   logic [31:0] sat_prod;
   logic        decide;

   // Positive dE never has bit 31 set, so its magnitude is just bits 30:0.
   always_comb begin
      de_nonpos = in_de[31] || (in_de == 32'd0);
      raw_prod  = {32'd0, in_beta} * {33'd0, in_de[30:0]};
      shifted   = raw_prod >> 16;
      sat_prod  = (|shifted[63:32]) ? 32'hFFFF_FFFF : shifted[31:0];
      decide    = s1_valid && (s1_force || (s1_prod < s1_nlog));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_force   <= 1'b0;
         s1_prod    <= 32'd0;
         s1_nlog    <= 32'd0;
         s1_tag     <= '0;
         out_valid  <= 1'b0;
         out_accept <= 1'b0;
         out_tag    <= '0;
      end else if (advance) begin
         s1_valid   <= in_valid;
         s1_force   <= de_nonpos;
         s1_prod    <= sat_prod;
         s1_nlog    <= in_nlog;
         s1_tag     <= in_tag;
         out_valid  <= s1_valid;
         out_accept <= decide;
         out_tag    <= s1_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
         n_total  <= '0;
         n_accept <= '0;
      end else if (out_valid && out_ready) begin
         n_total <= n_total + CNT_W'(1);
         if (out_accept) begin
            n_accept <= n_accept + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_metropolis_accept.sv
// Bench for metropolis_accept: directed vector table, corner-case sequences and
// randomized traffic scored against an arithmetic model of the acceptance rule.
module tb_metropolis_accept;
   localparam int TAG_W = 16;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_de = '0;
   logic [31:0]      in_beta = '0;
   logic [31:0]      in_nlog = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic             out_accept;
   logic [TAG_W-1:0] out_tag;
   logic             clr_stats = 1'b0;
   logic [CNT_W-1:0] n_total;
   logic [CNT_W-1:0] n_accept;

   metropolis_accept #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_de(in_de), .in_beta(in_beta), .in_nlog(in_nlog), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_accept(out_accept),
      .out_tag(out_tag), .clr_stats(clr_stats), .n_total(n_total), .n_accept(n_accept)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: accept when dE <= 0, else when beta*dE (16.16, saturated) < nlog.
   function automatic logic ref_accept(input logic [31:0] de, input logic [31:0] beta,
                                       input logic [31:0] nlog);
      longint     de_s;
      logic [63:0] p;
      de_s = longint'($signed(de));
      if (de_s <= 0) return 1'b1;
      p = (64'(beta) * 64'(de)) / 64'd65536;
      if (p > 64'hFFFF_FFFF) p = 64'hFFFF_FFFF;
      return p < 64'(nlog);
   endfunction

   // ---------------- scoreboard / monitor ----------------
   logic [TAG_W:0]   exp_q[$];
   logic [CNT_W-1:0] m_total = '0;
   logic [CNT_W-1:0] m_acc   = '0;
   bit               known = 1'b0;
   bit               last_xfer = 1'b0;
   bit               prev_stall = 1'b0;
   logic             prev_acc;
   logic [TAG_W-1:0] prev_tag;
   int               n_deliv = 0;

   always @(negedge clk) begin
      logic [TAG_W:0] e;
      if (known) begin
         check("n_total", n_total, m_total);
         check("n_accept", n_accept, m_acc);
         check("in_ready", in_ready, !out_valid || out_ready);
         if (prev_stall) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_accept", out_accept, prev_acc);
            check("stall_tag", out_tag, prev_tag);
         end
      end
      last_xfer  = 1'b0;
      prev_stall = 1'b0;
      if (rst) begin
         known   = 1'b1;
         m_total = '0;
         m_acc   = '0;
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("out_accept", out_accept, e[TAG_W]);
               check("out_tag", out_tag, e[TAG_W-1:0]);
               n_deliv++;
               m_total = m_total + 1;
               if (e[TAG_W]) m_acc = m_acc + 1;
            end
         end
         if (clr_stats) begin
            m_total = '0;
            m_acc   = '0;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back({ref_accept(in_de, in_beta, in_nlog), in_tag});
            last_xfer = 1'b1;
         end
         prev_stall = out_valid && !out_ready;
         prev_acc   = out_accept;
         prev_tag   = out_tag;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send(input logic [31:0] de, input logic [31:0] beta,
                       input logic [31:0] nlog, input logic [TAG_W-1:0] tag);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_de = de; in_beta = beta; in_nlog = nlog; in_tag = tag;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("send_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out();
      bit ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) check("out_timeout", 1'b0, 1'b1);
   endtask

   function automatic logic [31:0] rnd_de();
      case ($urandom_range(0, 3))
         0: return $urandom;
         1: return 32'($urandom_range(0, 32'h0004_0000));
         2: return -32'($urandom_range(0, 32'h0004_0000));
         default: return 32'($urandom_range(0, 32'h0000_4000));
      endcase
   endfunction

   function automatic logic [31:0] rnd_beta();
      return ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h0004_0000));
   endfunction

   // ---------------- test sequence ----------------
   typedef struct {
      logic [31:0] de;
      logic [31:0] beta;
      logic [31:0] nlog;
      logic        exp_acc;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int d0;
      vecs[0]  = '{32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
      vecs[1]  = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0001, 1'b1};
      vecs[2]  = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0};
      vecs[3]  = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h0007_FFFF, 1'b0};
      vecs[4]  = '{32'h8000_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
      vecs[5]  = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      vecs[6]  = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[7]  = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b1};
      vecs[8]  = '{32'h0000_8000, 32'h0002_0000, 32'h0001_0000, 1'b0};
      vecs[9]  = '{32'h0000_8000, 32'h0002_0000, 32'h0001_0001, 1'b1};
      vecs[10] = '{32'h0000_0001, 32'h0000_FFFF, 32'h0000_0001, 1'b1};

      do_reset();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_accept", out_accept, 1'b0);
      check("rst_out_tag", out_tag, '0);
      check("rst_n_total", n_total, '0);
      check("rst_in_ready", in_ready, 1'b1);

      // Directed table, one candidate at a time with the consumer always ready.
      for (int i = 0; i < 11; i++) begin
         send(vecs[i].de, vecs[i].beta, vecs[i].nlog, TAG_W'(i));
         wait_out();
         check("vec_accept", out_accept, vecs[i].exp_acc);
         check("vec_tag", out_tag, TAG_W'(i));
         @(posedge clk);
         #1;
         if (i == 0) begin
            check("first_n_total", n_total, 1);
            check("first_n_accept", n_accept, 1);
         end
      end

      // Back-to-back stream of 8 with a 3-cycle consumer stall mid-stream.
      d0 = n_deliv;
      fork
         begin
            for (int i = 0; i < 8; i++) send(rnd_de(), rnd_beta(), $urandom & 32'h7FFFF, TAG_W'(100 + i));
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("stall_in_ready", in_ready, 1'b0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      repeat (5) @(posedge clk);
      #1 check("stream_count", n_deliv - d0, 8);

      // Clear coinciding with an output transfer.
      send(32'h0000_0100, 32'h0001_0000, 32'h0000_0001, 16'h0aaa);
      wait_out();
      clr_stats = 1'b1;
      @(posedge clk);
      #1 clr_stats = 1'b0;
      check("clr_n_total", n_total, 0);
      check("clr_n_accept", n_accept, 0);
      send(32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000, 16'h0bbb);
      wait_out();
      @(posedge clk);
      #1 check("after_clr_n_total", n_total, 1);

      // Reset with two candidates in flight.
      out_ready = 1'b0;
      send(32'hFFFF_0000, 32'h0001_0000, 32'h0, 16'h0c01);
      send(32'hFFFF_0000, 32'h0001_0000, 32'h0, 16'h0c02);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_n_total", n_total, 0);
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1 check("no_stale_out", out_valid, 1'b0);
      end

      // Randomized traffic with random backpressure and occasional clears.
      for (int c = 0; c < 600; c++) begin
         @(posedge clk);
         #1;
         if (!in_valid || last_xfer) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_de    = rnd_de();
            in_beta  = rnd_beta();
            in_nlog  = $urandom & 32'h0007_FFFF;
            in_tag   = TAG_W'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         clr_stats = ($urandom_range(0, 39) == 0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      clr_stats = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1 check("drain_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/metropolis_accept.md
METROPOLIS_ACCEPT -- requirements
Module: metropolis_accept

Interface
REQ-001 Parameter TAG_W, default 16, width of the sideband tag carried with each decision.
REQ-002 Parameter CNT_W, default 32, width of the statistics counters.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  candidate move present.
REQ-006 in_ready  output  1  block accepts candidate this cycle.
REQ-007 in_de  input  32  energy change dE of candidate, signed 16.16 fixed point.
REQ-008 in_beta  input  32  inverse temperature, unsigned 16.16.
REQ-009 in_nlog  input  32  -ln(u) from the log-RNG stage, unsigned 16.16, bits 31:19 zero, 0 means u=1.
REQ-010 in_tag  input  TAG_W  sideband (e.g. site index), passed through unchanged.
REQ-011 out_valid  output  1  decision present.
REQ-012 out_ready  input  1  consumer takes decision.
REQ-013 out_accept  output  1  1 = move accepted.
REQ-014 out_tag  output  TAG_W  tag of the decided candidate.
REQ-015 clr_stats  input  1  synchronous clear of statistics counters.
REQ-016 n_total  output  CNT_W  decisions delivered since reset/clear.
REQ-017 n_accept  output  CNT_W  accepted decisions delivered since reset/clear.

Function
REQ-018 Two register stages S1 (product), S2 (decision); advance = !out_valid || out_ready; in_ready = advance; all stages load only when advance=1.
REQ-019 Input transfer = in_valid && in_ready; output transfer = out_valid && out_ready.
REQ-020 Latency: candidate transferred at edge N, out_valid asserted after edge N+1 when advance held high; bubbles propagate as invalid, not compacted.
REQ-021 S1: if in_de <= 0 (sign bit set or zero), flag force_accept=1; else product = in_beta * in_de magnitude, 64-bit unsigned, shifted right 16.
REQ-022 S1 saturation: if shifted product bits 63:32 nonzero, stored value = 0xFFFF_FFFF.
REQ-023 S2: out_accept = force_accept || (stored product < in_nlog), strict unsigned compare; in_nlog and tag registered alongside in S1.
REQ-024 in_nlog = 0 with dE > 0 -> reject, including in_beta = 0.
REQ-025 in_de = 0x8000_0000 (most negative) -> accept; no negation overflow path used.
REQ-026 While out_valid=1 and out_ready=0, out_accept, out_tag and all stage contents hold stable.
REQ-027 Each output transfer increments n_total; increments n_accept when out_accept=1; both wrap modulo 2^CNT_W.
REQ-028 clr_stats=1 zeroes both counters; an output transfer in the same cycle is not counted; pipeline unaffected.
REQ-029 out_ready has no combinational path to out_valid; in_ready depends combinationally on out_ready only.

Reset
REQ-030 rst=1: S1/S2 valid flags 0, out_valid=0, out_accept=0, out_tag=0, n_total=0, n_accept=0; in_ready=1 from the first cycle after reset.
REQ-031 rst mid-operation discards in-flight candidates; no counter update for them; rst overrides clr_stats and all transfers.

Verification
REQ-032 in_de=0xFFFF_0000 (-1.0), beta=1.0, nlog=0 -> out_accept=1 two edges later, n_total=1, n_accept=1.
REQ-033 in_de=0x0001_0000, beta=0x0001_0000, nlog=0x0001_0001 -> accept; nlog=0x0001_0000 -> reject (strict).
REQ-034 in_de=0x7FFF_0000, beta=0x7FFF_0000 -> saturated product, nlog=0x0007_FFFF -> reject.
REQ-035 Back-to-back stream of 8 candidates, out_ready low for 3 cycles mid-stream -> in_ready low those cycles, no loss/duplication, tags in order, outputs stable while stalled.
REQ-036 clr_stats asserted same cycle as an output transfer -> counters read 0 next cycle; next transfer gives n_total=1.
REQ-037 rst asserted with 2 candidates in flight -> out_valid=0 next cycle, counters 0, no stale decision emitted afterward.
